// File: rtl/ulx3s_sim_pkg.sv
// Shared constants for the ulx3s_sim register block: parameter defaults,
// event-vector layout, debounce counter width and the event priority rule.
package ulx3s_sim_pkg;

    localparam int SYNC_STAGES_DEF     = 2;
    localparam int DEBOUNCE_CYCLES_DEF = 4;
    localparam int DB_CNT_W            = 8;

    localparam int EV_SET = 0;
    localparam int EV_CLR = 1;
    localparam int EV_TGL = 2;
    localparam int NUM_EV = 3;

    typedef logic [NUM_EV-1:0] ev_vec_t;

    // Clear beats set, set beats toggle; a toggle only acts when alone.
    function automatic logic next_d(input logic cur, input ev_vec_t ev);
        logic nxt;
        if (ev[EV_CLR]) begin
            nxt = 1'b0;
        end else if (ev[EV_SET]) begin
            nxt = 1'b1;
        end else if (ev[EV_TGL]) begin
            nxt = ~cur;
        end else begin
            nxt = cur;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/ulx3s_sim_cond.sv
// Input conditioner: synchronizer, optional debounce (ULX3S_SIM_DEBOUNCE_EN)
// and rising-edge detector producing a one-cycle event pulse.
module ulx3s_sim_cond
    import ulx3s_sim_pkg::*;
#(
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic async_i,
    output logic rise_o
);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4 ||
        DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > ((1 << DB_CNT_W) - 1)) begin : g_bad_param
        $error("ulx3s_sim_cond: parameter out of legal range");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   filt_s;
    logic                   hist_q;

    // Synchronizer shift chain.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            sync_q <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
        end
    end

`ifdef ULX3S_SIM_DEBOUNCE_EN
    logic [DB_CNT_W-1:0] cnt_q;
    logic [DB_CNT_W-1:0] cnt_d;
    logic                filt_q;
    logic                filt_d;

    // Filtered level follows the synchronized level only after it has
    // differed for DEBOUNCE_CYCLES consecutive cycles.
    always_comb begin
        cnt_d  = cnt_q;
        filt_d = filt_q;
        if (sync_q[SYNC_STAGES-1] != filt_q) begin
            if (cnt_q == DB_CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                filt_d = sync_q[SYNC_STAGES-1];
                cnt_d  = {DB_CNT_W{1'b0}};
            end else begin
                cnt_d = cnt_q + {{(DB_CNT_W-1){1'b0}}, 1'b1};
            end
        end else begin
            cnt_d = {DB_CNT_W{1'b0}};
        end
    end

    // Debounce state registers.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            cnt_q  <= {DB_CNT_W{1'b0}};
            filt_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
        end
    end

    assign filt_s = filt_q;
`else
    assign filt_s = sync_q[SYNC_STAGES-1];
`endif

    // Edge-detector history; the pulse is combinational so the event lands
    // on d_o exactly SYNC_STAGES edges after first sampling.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            hist_q <= 1'b0;
        end else begin
            hist_q <= filt_s;
        end
    end

    assign rise_o = filt_s & ~hist_q;

endmodule

// File: rtl/ulx3s_sim_reg.sv
// Set/clear/toggle state register driven by three asynchronous requests.
// Define ULX3S_SIM_DEBOUNCE_EN to add a debounce filter per input.
module ulx3s_sim_reg
    import ulx3s_sim_pkg::*;
#(
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic d_o
);

    ev_vec_t req_s;
    ev_vec_t ev_s;
    logic    d_q;
    logic    d_d;

    assign req_s[EV_SET] = a_i;
    assign req_s[EV_CLR] = b_i;
    assign req_s[EV_TGL] = c_i;

    for (genvar i = 0; i < NUM_EV; i++) begin : g_cond
        ulx3s_sim_cond #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_cond (
            .clk_i   (clk_i),
            .reset_i (reset_i),
            .async_i (req_s[i]),
            .rise_o  (ev_s[i])
        );
    end

    // Next-state selection by event priority.
    always_comb begin
        d_d = next_d(d_q, ev_s);
    end

    // State register.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d_d;
        end
    end

    assign d_o = d_q;

endmodule

// File: tb/tb_ulx3s_sim_reg.sv
// Self-checking bench for ulx3s_sim_reg: table of single-cycle request
// patterns plus hand-written reset, hold-high and back-to-back sequences.
module tb_ulx3s_sim_reg;
    import ulx3s_sim_pkg::*;

    localparam int SS = SYNC_STAGES_DEF;
`ifdef ULX3S_SIM_DEBOUNCE_EN
    localparam int DB = DEBOUNCE_CYCLES_DEF;
`else
    localparam int DB = 0;
`endif
    localparam int LAT = SS + DB;
    localparam int PW  = (DB == 0) ? 1 : DB + 1;
    localparam int GAP = LAT + 8 + DB;

    typedef struct {
        logic a;
        logic b;
        logic c;
        logic exp_d;
    } vec_t;

    typedef struct {
        int   due;
        logic exp;
        int   id;
    } sb_t;

    logic clk = 1'b0;
    logic rst_n;
    logic a, b, c;
    logic d;

    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    sb_t  sb[$];
    logic cur;

    ulx3s_sim_reg dut (
        .clk_i   (clk),
        .reset_i (rst_n),
        .a_i     (a),
        .b_i     (b),
        .c_i     (c),
        .d_o     (d)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input int id, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s[%0d] cyc=%0d: d_o=%b expected %b", nm, id, cyc, act, exp);
        end
    endtask

    task automatic expect_at(input int due, input logic v, input int id);
        sb.push_back('{due: due, exp: v, id: id});
    endtask

    task automatic pulse(input logic va, input logic vb, input logic vc,
                         input logic old_d, input logic new_d, input int id);
        int n;
        @(negedge clk);
        n = cyc + 1;
        expect_at(n + LAT - 1, old_d, id);
        expect_at(n + LAT,     new_d, id);
        expect_at(n + LAT + 3, new_d, id);
        a = va; b = vb; c = vc;
        repeat (PW) @(negedge clk);
        a = 1'b0; b = 1'b0; c = 1'b0;
        repeat (GAP) @(negedge clk);
    endtask

    // Scoreboard consumer: compare d_o whenever an expectation falls due.
    initial begin
        sb_t e;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                check("sb", e.id, d, e.exp);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        vec_t tbl[14];
        int   n;
        int   w;

        tbl[0]  = '{a:1'b1, b:1'b0, c:1'b0, exp_d:1'b1};
        tbl[1]  = '{a:1'b1, b:1'b0, c:1'b0, exp_d:1'b1};
        tbl[2]  = '{a:1'b0, b:1'b1, c:1'b0, exp_d:1'b0};
        tbl[3]  = '{a:1'b0, b:1'b1, c:1'b0, exp_d:1'b0};
        tbl[4]  = '{a:1'b0, b:1'b0, c:1'b1, exp_d:1'b1};
        tbl[5]  = '{a:1'b0, b:1'b0, c:1'b1, exp_d:1'b0};
        tbl[6]  = '{a:1'b0, b:1'b0, c:1'b1, exp_d:1'b1};
        tbl[7]  = '{a:1'b0, b:1'b1, c:1'b0, exp_d:1'b0};
        tbl[8]  = '{a:1'b1, b:1'b1, c:1'b0, exp_d:1'b0};
        tbl[9]  = '{a:1'b1, b:1'b0, c:1'b1, exp_d:1'b1};
        tbl[10] = '{a:1'b0, b:1'b1, c:1'b1, exp_d:1'b0};
        tbl[11] = '{a:1'b1, b:1'b1, c:1'b1, exp_d:1'b0};
        tbl[12] = '{a:1'b0, b:1'b0, c:1'b1, exp_d:1'b1};
        tbl[13] = '{a:1'b1, b:1'b1, c:1'b0, exp_d:1'b0};

        a = 1'b0; b = 1'b0; c = 1'b0;
        rst_n = 1'b0;
        #1;
        check("reset", 0, d, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle", i, d, 1'b0);
        end

        cur = 1'b0;
        for (int i = 0; i < 14; i++) begin
            pulse(tbl[i].a, tbl[i].b, tbl[i].c, cur, tbl[i].exp_d, 100 + i);
            cur = tbl[i].exp_d;
        end

        // c held high for several cycles toggles exactly once.
        @(negedge clk);
        n = cyc + 1;
        expect_at(n + LAT - 1, cur,  200);
        expect_at(n + LAT,     ~cur, 201);
        expect_at(n + LAT + 4, ~cur, 202);
        c = 1'b1;
        repeat (6) @(negedge clk);
        c = 1'b0;
        expect_at(cyc + 1 + LAT + 2, ~cur, 203);
        cur = ~cur;
        repeat (GAP) @(negedge clk);

`ifndef ULX3S_SIM_DEBOUNCE_EN
        // Two c pulses separated by one low sampled cycle toggle twice.
        @(negedge clk);
        n = cyc + 1;
        expect_at(n + LAT - 1, cur,  300);
        expect_at(n + LAT,     ~cur, 301);
        expect_at(n + LAT + 1, ~cur, 302);
        expect_at(n + LAT + 2, cur,  303);
        expect_at(n + LAT + 4, cur,  304);
        c = 1'b1;
        @(negedge clk);
        c = 1'b0;
        @(negedge clk);
        c = 1'b1;
        @(negedge clk);
        c = 1'b0;
        repeat (GAP) @(negedge clk);
`endif

        // Async reset mid-operation with a clear in flight, a held across release.
        if (cur == 1'b0) begin
            pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 400);
            cur = 1'b1;
        end
        @(negedge clk);
        b = 1'b1;
        repeat (PW) @(negedge clk);
        b = 1'b0;
        #2;
        rst_n = 1'b0;
        a = 1'b1;
        #1;
        check("async_reset", 401, d, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("in_reset", 402, d, 1'b0);
        rst_n = 1'b1;
        n = cyc + 1;
        expect_at(n + LAT - 1, 1'b0, 403);
        expect_at(n + LAT,     1'b1, 404);
        expect_at(n + LAT + 3, 1'b1, 405);
        repeat (LAT + 6) @(negedge clk);
        a = 1'b0;
        cur = 1'b1;
        repeat (GAP) @(negedge clk);

`ifdef ULX3S_SIM_DEBOUNCE_EN
        // A 2-cycle glitch on a is shorter than the debounce window.
        pulse(1'b0, 1'b1, 1'b0, cur, 1'b0, 500);
        cur = 1'b0;
        @(negedge clk);
        n = cyc + 1;
        a = 1'b1;
        repeat (2) @(negedge clk);
        a = 1'b0;
        expect_at(n + LAT + 2, 1'b0, 501);
        expect_at(n + LAT + 6, 1'b0, 502);
        repeat (GAP) @(negedge clk);
`endif

        w = 0;
        while (sb.size() > 0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (sb.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d expectations outstanding, expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ulx3s_sim_reg.md
ULX3S_SIM_REG -- requirements
Module: ulx3s_sim_reg

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchronizer depth per input, legal range 2..4.
REQ-002 Parameter DEBOUNCE_CYCLES, default 4: stable-cycle count for the debounce filter, legal range 1..255; used only when DEBOUNCE_EN is defined.
REQ-003 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 reset_i  input  1  asynchronous, active-low reset: 0 = reset asserted.
REQ-005 a_i  input  1  asynchronous "set" request.
REQ-006 b_i  input  1  asynchronous "clear" request.
REQ-007 c_i  input  1  asynchronous "toggle" request.
REQ-008 d_o  output  1  state register value, driven directly from a flop.

Function
REQ-009 Each of a_i, b_i and c_i SHALL pass through a SYNC_STAGES-flop synchronizer, then a rising-edge detector that emits a one-cycle event pulse.
REQ-010 An a event SHALL set d_o to 1, a b event SHALL clear d_o to 0, and a c event SHALL invert d_o.
REQ-011 Priority when events coincide in the same cycle: b > a > c; the b+c and a+c cases SHALL ignore the toggle.
REQ-012 Latency: an input sampled high for the first time at rising edge N SHALL update d_o at rising edge N+SYNC_STAGES (edge N+2 by default).
REQ-013 Only 0->1 transitions SHALL generate events; held-high inputs and 1->0 transitions SHALL have no effect.
REQ-014 Repeated events of the same kind SHALL be idempotent: a second set leaves d_o at 1, and a second clear leaves it at 0.
REQ-015 Back-to-back c pulses separated by at least one low sampled cycle SHALL each toggle d_o.

Reset
REQ-016 While reset_i = 0, d_o, all synchronizer flops, edge-detector history and debounce state SHALL be 0, immediately and without waiting for a clock edge.
REQ-017 An input held high across reset deassertion SHALL be seen as a rising edge and produce exactly one event SHALL.
REQ-018 Reset asserted mid-operation SHALL discard any in-flight event.

Configuration
REQ-019 When macro ULX3S_SIM_DEBOUNCE_EN is defined, each synchronized input SHALL change its filtered level only after holding a new value for DEBOUNCE_CYCLES consecutive cycles; edge detection SHALL operate on the filtered level, adding DEBOUNCE_CYCLES cycles to the REQ-012 latency.
REQ-020 When ULX3S_SIM_DEBOUNCE_EN is not defined, no filter logic SHALL exist and the REQ-012 latency SHALL apply exactly.

Structure
REQ-021 Package ulx3s_sim_pkg SHALL hold the parameter defaults, the event-vector index constants (EV_SET=0, EV_CLR=1, EV_TGL=2) and the debounce counter width.
REQ-022 Sub-module ulx3s_sim_cond (synchronizer, optional debounce, edge detect) SHALL be instantiated once per input; the top level holds only the priority logic and the d_o flop.

Verification
REQ-023 Apply reset_i=0 for 1 cycle with all inputs at 0, then release -> d_o=0 and stays 0 for 10 cycles.
REQ-024 Pulse a_i=1 for 1 cycle -> d_o=1 two edges later (debounce off), then remains 1; pulse a_i again -> d_o stays 1.
REQ-025 With d_o=1, pulse b_i -> d_o=0 two edges later.
REQ-026 Apply three separated c_i pulses starting with d_o=0 -> d_o sequence 1,0,1.
REQ-027 Raise a_i and b_i in the same cycle with d_o=0 -> d_o remains 0; raise a_i and c_i together -> d_o=1.
REQ-028 Pull reset_i low while d_o=1 between clock edges -> d_o=0 immediately; with a_i held high across the release -> d_o=1 two edges after release; with the macro defined, a 2-cycle glitch on a_i (DEBOUNCE_CYCLES=4) -> no change.
